// File: rtl/dsp38_mult_stream_if.sv
// Valid/ready stream carrying one packed payload word per transfer.
// The producer side uses the master modport; the consumer uses slave.
interface dsp38_mult_stream_if #(
    parameter int unsigned Width = 8
);
    logic             valid;
    logic             ready;
    logic [Width-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dsp38_mult_stream.sv
// Streaming front-end for a DSP38 in combinational MULTIPLY mode: registers operands onto the
// DSP pins, captures Z/DLY_B one cycle later into a credit-protected result FIFO.
module dsp38_mult_stream #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    // data = {unsigned_b, unsigned_a, b[17:0], a[19:0]}
    dsp38_mult_stream_if.slave         in_s,
    // data = {z[37:0], dly_b[17:0]}
    dsp38_mult_stream_if.master        out_m,
    output logic [19:0]                dsp_a,
    output logic [17:0]                dsp_b,
    output logic                       dsp_unsigned_a,
    output logic                       dsp_unsigned_b,
    output logic [5:0]                 dsp_acc_fir,
    output logic [2:0]                 dsp_feedback,
    output logic                       dsp_load_acc,
    output logic                       dsp_saturate,
    output logic                       dsp_round,
    output logic                       dsp_subtract,
    output logic [5:0]                 dsp_shift_right,
    input  logic [37:0]                dsp_z,
    input  logic [17:0]                dsp_dly_b,
    output logic [15:0]                txn_count,
    output logic                       busy
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [55:0] entry_t;

    logic            reset_q;
    logic            op_vld_q;
    logic [19:0]     dsp_a_q;
    logic [17:0]     dsp_b_q;
    logic            dsp_ua_q;
    logic            dsp_ub_q;
    logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     txn_q;
    entry_t          mem_q [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic            out_vld;
    logic [CntW:0]   credit_used;

    // Credits count both stored results and the operand still in flight to the DSP.
    assign credit_used = {1'b0, count_q} + {{CntW{1'b0}}, op_vld_q};
    assign in_s.ready  = !reset_q && (credit_used < (CntW + 1)'(DEPTH));

    assign accept  = in_s.valid && in_s.ready;
    assign push    = op_vld_q;
    assign out_vld = (count_q != '0);
    assign pop     = out_vld && out_m.ready;

    assign out_m.valid = out_vld;
    assign out_m.data  = out_vld ? mem_q[rd_ptr_q[PtrW-1:0]] : '0;

    assign dsp_a           = dsp_a_q;
    assign dsp_b           = dsp_b_q;
    assign dsp_unsigned_a  = dsp_ua_q;
    assign dsp_unsigned_b  = dsp_ub_q;
    assign dsp_acc_fir     = '0;
    assign dsp_feedback    = '0;
    assign dsp_load_acc    = 1'b0;
    assign dsp_saturate    = 1'b0;
    assign dsp_round       = 1'b0;
    assign dsp_subtract    = 1'b0;
    assign dsp_shift_right = '0;

    assign txn_count = txn_q;
    assign busy      = op_vld_q || out_vld;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q + {{(CntW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(CntW-1){1'b0}}, pop};
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            op_vld_q <= 1'b0;
            dsp_a_q  <= '0;
            dsp_b_q  <= '0;
            dsp_ua_q <= 1'b0;
            dsp_ub_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            txn_q    <= '0;
        end else begin
            op_vld_q <= accept;
            if (accept) begin
                dsp_a_q  <= in_s.data[19:0];
                dsp_b_q  <= in_s.data[37:20];
                dsp_ua_q <= in_s.data[38];
                dsp_ub_q <= in_s.data[39];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (pop) begin
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    // Storage carries no reset; out_m.data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= {dsp_z, dsp_dly_b};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CntW'(DEPTH))));

endmodule
